// File: rtl/uart_rx_deserializer.sv
// UART receive front end: synchronises rx_in, qualifies the start bit and
// shifts in 9 mid-bit samples (7 data LSB first, parity, stop) into data_out.
module uart_rx_deserializer #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    output logic [8:0] data_out,
    output logic       load,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned WORD_W = 9;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORD_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
    logic [WORD_W-1:0]   data_q, data_d;
    logic                frame_err_q, frame_err_d;
    logic                load_q, load_d;
    logic                busy_q, busy_d;
    logic                rx_meta_q, rx_s_q;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_in;
            rx_s_q    <= rx_meta_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            data_q      <= '1;
            frame_err_q <= 1'b0;
            load_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            data_q      <= data_d;
            frame_err_q <= frame_err_d;
            load_q      <= load_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic; load/busy are derived from the next state so they register in step with it.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        data_d      = data_q;
        frame_err_d = frame_err_q;

        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                if (!rx_s_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    // A line that has returned high by mid start bit was a glitch.
                    state_d   = rx_s_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d  = '0;
                    data_d = {rx_s_q, data_q[WORD_W-1:1]};
                    if (bit_idx_q == LAST_IDX) begin
                        frame_err_d = ~rx_s_q;
                        bit_idx_d   = '0;
                        state_d     = DONE;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        load_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    assign data_out  = data_q;
    assign load      = load_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule

// File: doc/uart_rx_deserializer.md
# uart_rx_deserializer

Receive-side serial front end of the UART. It synchronises the asynchronous `rx_in` line, detects and qualifies the start bit, and samples 9 bits at mid-bit: 7 data bits LSB first, then the parity bit, then the stop bit. It assembles them into a 9-bit word and issues a one-cycle `load` strobe. The downstream receive data register captures `data_out` on that strobe; the error detector and 7-segment decoder read from that register.

## Interface
- `CLKS_PER_BIT`, default 434 (50 MHz / 115200 baud): clock cycles per serial bit. Must be even and ≥ 4.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset; one clock domain only.
- `rx_in`  in  1  asynchronous serial line, idle high.
- `data_out`  out  9  assembled word {stop, parity, data[6:0]}.
- `load`  out  1  one-cycle strobe; `data_out` holds a complete frame while it is high.
- `frame_err`  out  1  stop bit of the last completed frame was sampled 0.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- **Synchroniser:** two-flop synchroniser on `rx_in` produces `rx_s`. Both flops reset to 1.
- **Counters:**
  - `cnt` has width $clog2(CLKS_PER_BIT) and is an unsigned up-counter.
  - `bit_idx` is 4 bits wide and counts 0..8.
- **FSM states:** IDLE, START, DATA, DONE.
  - IDLE: `cnt` = 0. If `rx_s` == 0, go to START.
  - START: `cnt` increments. When `cnt` == CLKS_PER_BIT/2−1, sample `rx_s`.
    - If `rx_s` == 0: go to DATA with `cnt` = 0 and `bit_idx` = 0.
    - If `rx_s` == 1: the low pulse was a glitch; return to IDLE with no output change.
  - DATA: `cnt` increments. When `cnt` == CLKS_PER_BIT−1:
    - right-shift `data_out` with `rx_s` entering bit 8;
    - set `cnt` = 0 and increment `bit_idx`;
    - on the shift with `bit_idx` == 8 (the 9th bit), also set `frame_err` <= ~`rx_s` and go to DONE.
  - DONE: `load` = 1 for exactly this cycle. Go to IDLE unconditionally.
- **Bit mapping:** after 9 shifts, the first received bit (d0) sits in `data_out[0]`, parity in `[7]`, stop in `[8]`.
- **No parity check:** parity is passed through unchecked; checking belongs to the error detector.
- **Mid-frame visibility:** `data_out` changes during DATA. Downstream logic must sample it only while `load` is high.
- **Frame errors:** a frame with a stop bit of 0 still produces `load`, and `frame_err` = 1.
  - `frame_err` holds its value until the next 9th-bit shift.
  - After DONE, the FSM re-enters IDLE in the middle of the stop bit. If the line is still low (framing error), that low level is treated as a new start bit. This is accepted behaviour.
- **Reset values** (applied in any state, including mid-frame; the partial frame is discarded):
  - `data_out` = 9'h1FF
  - `load` = 0
  - `frame_err` = 0
  - `busy` = 0
  - FSM = IDLE
  - `cnt` = 0, `bit_idx` = 0
- **No handshake:** there is no back-pressure. `load` fires regardless of the downstream state.

## Timing
- Edge e0 is the first `clk` edge at which the synchroniser samples `rx_in` low.
  - `rx_s` goes low after e1.
  - START is entered after e2.
  - The start bit is validated at e2+CLKS_PER_BIT/2.
- The 9th shift occurs at e(2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT). `load` is high during the following cycle.
  - For CLKS_PER_BIT = 8: the shift is at e78, and `load` is high between e78 and e79.
- All outputs are registered. `busy` rises the cycle START is entered and falls the cycle after DONE.
- Minimum spacing between `load` pulses is 10·CLKS_PER_BIT − CLKS_PER_BIT/2 cycles.
- The sampling point is the mid-bit, offset by the 2-cycle synchroniser delay. Baud tolerance is about ±4% across the 10-bit frame.

## Test plan
All scenarios use CLKS_PER_BIT = 8.
- **Reset:** hold `reset` = 1 for 3 cycles with `rx_in` = 0 -> `data_out` = 9'h1FF, `load` = 0, `frame_err` = 0, `busy` = 0.
- **Good frame:** send start, data 7'h55 LSB first, parity 0, stop 1 -> a single `load` pulse exactly 78 edges after e0; `data_out` = 9'h155; `frame_err` = 0.
- **Framing error:** send data 7'h2A, parity 1, stop 0 -> `load` pulses; `data_out` = 9'h0AA; `frame_err` = 1.
- **Next good frame after error:** send data 7'h7F, parity 1, stop 1 -> `data_out` = 9'h1FF and `frame_err` clears to 0.
- **Start glitch:** drive `rx_in` low for 2 cycles, then high -> `busy` pulses, FSM returns to IDLE, no `load`, `data_out` unchanged.
- **Reset mid-frame:** assert `reset` after 4 data bits -> all outputs return to reset values next edge. A frame sent after release (7'h01, stop 1) yields `data_out` = 9'h101.
- **Back-to-back frames:** two frames with zero idle time between them -> two `load` pulses 80 cycles apart, each word correct.
